// File: rtl/io_ef_pkg.sv
// Shared constants and address-translate helpers for the I/O empty/full pipeline.
package io_ef_pkg;

    localparam int MAX_PORT_COUNT = 32;
    localparam int MAX_PIPE_DEPTH = 8;

    function automatic logic port_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned count);
        logic [32:0] limit;
        limit = {1'b0, base} + 33'(count);
        return (addr >= base) && ({1'b0, addr} < limit);
    endfunction

    function automatic logic [31:0] port_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/io_ef_lookup.sv
// One operand channel: address translate, empty/full select and in-flight test.
module io_ef_lookup
    import io_ef_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 10,
    parameter int          PORT_COUNT     = 8,
    parameter int unsigned PORT_BASE_ADDR = 0,
    parameter bit          IS_WRITE       = 1'b0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  used,
    input  logic [PORT_COUNT-1:0] ef,
    input  logic [PORT_COUNT-1:0] in_flight,
    output logic                  block,
    output logic [PORT_COUNT-1:0] select
);

    logic [31:0] addr_ext;
    logic [31:0] offset;
    logic        hit;
    logic        ef_set;
    logic        busy;

    always_comb begin
        addr_ext = 32'(addr);
        hit      = used && port_hit(addr_ext, 32'(PORT_BASE_ADDR), PORT_COUNT);
        offset   = port_index(addr_ext, 32'(PORT_BASE_ADDR));
        select   = '0;
        if (hit) begin
            select = PORT_COUNT'(1) << offset;
        end
        ef_set = |(ef & select);
        busy   = |(in_flight & select);
        // reads stall on an empty port, writes stall on a full one
        block  = hit && (busy || (IS_WRITE ? ef_set : !ef_set));
    end

endmodule

// File: rtl/io_ef_pipeline.sv
// Checks instruction I/O operands against port empty/full flags and delays
// accepted port accesses through a commit pipeline to one-cycle pulses.
module io_ef_pipeline
    import io_ef_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 10,
    parameter int          PORT_COUNT     = 8,
    parameter int unsigned PORT_BASE_ADDR = 0,
    parameter int          READ_CHANNELS  = 2,
    parameter int          PIPE_DEPTH     = 4,
    parameter int          COUNT_WIDTH    = 16
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [PORT_COUNT-1:0]               in_port_EF,
    input  logic [PORT_COUNT-1:0]               out_port_EF,
    input  logic                                instr_valid,
    input  logic [READ_CHANNELS*ADDR_WIDTH-1:0] read_addr,
    input  logic [ADDR_WIDTH-1:0]               write_addr,
    input  logic                                write_used,
    input  logic                                count_clear,
    output logic                                io_ready,
    output logic                                annul,
    output logic [PORT_COUNT-1:0]               in_port_rden,
    output logic [PORT_COUNT-1:0]               out_port_wren,
    output logic [COUNT_WIDTH-1:0]              annul_count
);

    logic [PORT_COUNT-1:0] rd_stage [PIPE_DEPTH];
    logic [PORT_COUNT-1:0] wr_stage [PIPE_DEPTH];
    logic [PORT_COUNT-1:0] rd_in_flight;
    logic [PORT_COUNT-1:0] wr_in_flight;
    logic [PORT_COUNT-1:0] rd_sel [READ_CHANNELS];
    logic [READ_CHANNELS-1:0] rd_block;
    logic [PORT_COUNT-1:0] wr_sel;
    logic                  wr_block;
    logic [PORT_COUNT-1:0] rd_mask;
    logic                  any_block;
    logic                  go;
    logic                  stop;

    always_comb begin
        rd_in_flight = '0;
        wr_in_flight = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            rd_in_flight |= rd_stage[i];
            wr_in_flight |= wr_stage[i];
        end
    end

    for (genvar g = 0; g < READ_CHANNELS; g++) begin : g_read
        io_ef_lookup #(
            .ADDR_WIDTH     (ADDR_WIDTH),
            .PORT_COUNT     (PORT_COUNT),
            .PORT_BASE_ADDR (PORT_BASE_ADDR),
            .IS_WRITE       (1'b0)
        ) u_lookup (
            .addr      (read_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .used      (1'b1),
            .ef        (in_port_EF),
            .in_flight (rd_in_flight),
            .block     (rd_block[g]),
            .select    (rd_sel[g])
        );
    end

    io_ef_lookup #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .PORT_COUNT     (PORT_COUNT),
        .PORT_BASE_ADDR (PORT_BASE_ADDR),
        .IS_WRITE       (1'b1)
    ) u_write_lookup (
        .addr      (write_addr),
        .used      (write_used),
        .ef        (out_port_EF),
        .in_flight (wr_in_flight),
        .block     (wr_block),
        .select    (wr_sel)
    );

    // duplicate read channels on one port collapse into a single mask bit
    always_comb begin
        rd_mask   = '0;
        any_block = wr_block;
        for (int ch = 0; ch < READ_CHANNELS; ch++) begin
            rd_mask   |= rd_sel[ch];
            any_block |= rd_block[ch];
        end
        go   = instr_valid && !any_block;
        stop = instr_valid && any_block;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            io_ready      <= 1'b0;
            annul         <= 1'b0;
            rd_stage      <= '{default: '0};
            wr_stage      <= '{default: '0};
            in_port_rden  <= '0;
            out_port_wren <= '0;
        end else begin
            io_ready    <= go;
            annul       <= stop;
            rd_stage[0] <= go ? rd_mask : '0;
            wr_stage[0] <= go ? wr_sel : '0;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                rd_stage[i] <= rd_stage[i-1];
                wr_stage[i] <= wr_stage[i-1];
            end
            in_port_rden  <= rd_stage[PIPE_DEPTH-1];
            out_port_wren <= wr_stage[PIPE_DEPTH-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            annul_count <= '0;
        end else if (count_clear) begin
            annul_count <= '0;
        end else if (annul && !(&annul_count)) begin
            annul_count <= annul_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_io_ef_pipeline.sv
// Directed bench for io_ef_pipeline: port base 0x200, depth 4, plus a 2-bit counter copy.
module tb_io_ef_pipeline;

    localparam int AW = 10;
    localparam int PC = 8;
    localparam int RC = 2;
    localparam int PD = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [PC-1:0] in_port_EF;
    logic [PC-1:0] out_port_EF;
    logic          instr_valid;
    logic [RC*AW-1:0] read_addr;
    logic [AW-1:0] write_addr;
    logic          write_used;
    logic          count_clear;

    logic          io_ready, annul;
    logic [PC-1:0] in_port_rden, out_port_wren;
    logic [15:0]   annul_count;

    logic          c_io_ready, c_annul;
    logic [PC-1:0] c_rden, c_wren;
    logic [1:0]    c_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    io_ef_pipeline #(
        .ADDR_WIDTH(AW), .PORT_COUNT(PC), .PORT_BASE_ADDR('h200),
        .READ_CHANNELS(RC), .PIPE_DEPTH(PD), .COUNT_WIDTH(16)
    ) dut (
        .clock(clock), .reset_n(reset_n), .in_port_EF(in_port_EF),
        .out_port_EF(out_port_EF), .instr_valid(instr_valid), .read_addr(read_addr),
        .write_addr(write_addr), .write_used(write_used), .count_clear(count_clear),
        .io_ready(io_ready), .annul(annul), .in_port_rden(in_port_rden),
        .out_port_wren(out_port_wren), .annul_count(annul_count)
    );

    io_ef_pipeline #(
        .ADDR_WIDTH(AW), .PORT_COUNT(PC), .PORT_BASE_ADDR('h200),
        .READ_CHANNELS(RC), .PIPE_DEPTH(PD), .COUNT_WIDTH(2)
    ) dut_c (
        .clock(clock), .reset_n(reset_n), .in_port_EF(in_port_EF),
        .out_port_EF(out_port_EF), .instr_valid(instr_valid), .read_addr(read_addr),
        .write_addr(write_addr), .write_used(write_used), .count_clear(count_clear),
        .io_ready(c_io_ready), .annul(c_annul), .in_port_rden(c_rden),
        .out_port_wren(c_wren), .annul_count(c_count)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        in_port_EF  = '0;
        out_port_EF = '0;
        instr_valid = 1'b0;
        read_addr   = '0;
        write_addr  = '0;
        write_used  = 1'b0;
        count_clear = 1'b0;
        step();
        step();
        check("rst_io_ready", 32'(io_ready), 0);
        check("rst_annul", 32'(annul), 0);
        check("rst_rden", 32'(in_port_rden), 0);
        check("rst_wren", 32'(out_port_wren), 0);
        check("rst_count", 32'(annul_count), 0);
        reset_n = 1'b1;
        step();

        // single read of port 2; channel 1 points below the port window
        in_port_EF  = 8'h04;
        read_addr   = {10'h000, 10'h202};
        instr_valid = 1'b1;
        step();
        check("rd_ready", 32'(io_ready), 1);
        check("rd_annul", 32'(annul), 0);
        instr_valid = 1'b0;
        for (int k = 1; k <= PD + 1; k++) begin
            step();
            check("rd_pulse", 32'(in_port_rden), (k == PD) ? 32'h04 : 32'h00);
        end

        // write to a full port is annulled
        out_port_EF = 8'h01;
        write_addr  = 10'h200;
        write_used  = 1'b1;
        read_addr   = {10'h000, 10'h000};
        instr_valid = 1'b1;
        step();
        check("wr_annul", 32'(annul), 1);
        check("wr_ready", 32'(io_ready), 0);
        instr_valid = 1'b0;
        write_used  = 1'b0;
        step();
        check("wr_annul_drop", 32'(annul), 0);
        check("wr_count", 32'(annul_count), 1);
        for (int k = 1; k <= PD + 1; k++) begin
            step();
            check("wr_no_pulse", 32'(out_port_wren), 0);
        end
        out_port_EF = 8'h00;

        // back-to-back reads of port 3: second sees first in flight
        in_port_EF  = 8'h08;
        read_addr   = {10'h000, 10'h203};
        instr_valid = 1'b1;
        step();
        check("b2b_first_ready", 32'(io_ready), 1);
        step();
        check("b2b_second_annul", 32'(annul), 1);
        check("b2b_second_ready", 32'(io_ready), 0);
        instr_valid = 1'b0;
        step();
        check("b2b_count", 32'(annul_count), 2);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("b2b_pulse", 32'(in_port_rden), (k == 2) ? 32'h08 : 32'h00);
        end

        // both channels on port 1 give a single bit
        in_port_EF  = 8'h02;
        read_addr   = {10'h201, 10'h201};
        instr_valid = 1'b1;
        step();
        check("dup_ready", 32'(io_ready), 1);
        instr_valid = 1'b0;
        for (int k = 1; k <= PD + 1; k++) begin
            step();
            check("dup_pulse", 32'(in_port_rden), (k == PD) ? 32'h02 : 32'h00);
        end

        // non-port address with every port empty
        in_port_EF  = 8'h00;
        read_addr   = {10'h050, 10'h050};
        instr_valid = 1'b1;
        step();
        check("nohit_ready", 32'(io_ready), 1);
        check("nohit_annul", 32'(annul), 0);
        instr_valid = 1'b0;
        for (int k = 1; k <= PD + 1; k++) begin
            step();
            check("nohit_no_pulse", 32'(in_port_rden), 0);
        end

        // reset while a write is in flight
        write_addr  = 10'h205;
        write_used  = 1'b1;
        instr_valid = 1'b1;
        step();
        check("rstmid_ready", 32'(io_ready), 1);
        instr_valid = 1'b0;
        write_used  = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        step();
        step();
        check("rstmid_io_ready", 32'(io_ready), 0);
        check("rstmid_wren", 32'(out_port_wren), 0);
        check("rstmid_count", 32'(annul_count), 0);
        reset_n = 1'b1;
        for (int k = 1; k <= PD + 2; k++) begin
            step();
            check("rstmid_no_pulse", 32'(out_port_wren), 0);
        end

        // read and write of the same port are checked independently
        in_port_EF  = 8'h10;
        out_port_EF = 8'h00;
        read_addr   = {10'h000, 10'h204};
        write_addr  = 10'h204;
        write_used  = 1'b1;
        instr_valid = 1'b1;
        step();
        check("rw_ready", 32'(io_ready), 1);
        instr_valid = 1'b0;
        write_used  = 1'b0;
        for (int k = 1; k <= PD; k++) begin
            step();
            check("rw_rden", 32'(in_port_rden), (k == PD) ? 32'h10 : 32'h00);
            check("rw_wren", 32'(out_port_wren), (k == PD) ? 32'h10 : 32'h00);
        end

        // saturation on the 2-bit counter, then clear against an annul
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        check("sat_cleared", 32'(c_count), 0);
        out_port_EF = 8'h01;
        write_addr  = 10'h200;
        write_used  = 1'b1;
        instr_valid = 1'b1;
        for (int k = 0; k < 5; k++) step();
        instr_valid = 1'b0;
        step();
        check("sat_count2", 32'(c_count), 3);
        check("sat_count16", 32'(annul_count), 5);
        instr_valid = 1'b1;
        count_clear = 1'b1;
        step();
        instr_valid = 1'b0;
        check("clr_annul_seen", 32'(c_annul), 1);
        step();
        check("clr_wins2", 32'(c_count), 0);
        check("clr_wins16", 32'(annul_count), 0);
        count_clear = 1'b0;
        write_used  = 1'b0;
        step();
        check("clr_hold", 32'(c_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
